// File: rtl/led_arb_pkg.sv
// Shared definitions for the status-LED arbiter: pattern codes, FSM states
// and the round-robin search helper.
package led_arb_pkg;

  typedef enum logic [1:0] {
    PAT_OFF  = 2'b00,
    PAT_ON   = 2'b01,
    PAT_SLOW = 2'b10,
    PAT_FAST = 2'b11
  } pat_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } state_e;

  // First set request strictly after 'last', wrapping over n entries (n <= 8).
  // Returns 'last' when nothing is set; callers gate on |req.
  function automatic int unsigned rr_next(input logic [7:0] req,
                                          input int unsigned last,
                                          input int unsigned n);
    int unsigned idx;
    logic        found;
    rr_next = last;
    found   = 1'b0;
    for (int unsigned k = 1; k <= 8; k++) begin
      idx = (last + k) % n;
      if (!found && k <= n && req[idx[2:0]]) begin
        rr_next = idx;
        found   = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/led_share_arbiter_if.sv
// Requester/LED bundle of the status-LED arbiter.
// master: requesters side, slave: arbiter side.
interface led_share_arbiter_if #(
  parameter int unsigned N_REQ = 4
) ();
  logic [N_REQ-1:0]   req;
  logic [2*N_REQ-1:0] pattern;
  logic               led;
  logic [N_REQ-1:0]   grant;
  logic               grant_valid;
  logic               slot_done;

  modport master (output req, pattern, input led, grant, grant_valid, slot_done);
  modport slave  (input req, pattern, output led, grant, grant_valid, slot_done);
endinterface

// File: rtl/button_debounce.sv
// Push-button conditioner: 2-FF synchronizer, stable-time filter and a
// one-cycle pulse on each debounced rising edge.
module button_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic button,
  output logic rise
);
  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic [1:0]       sync;
  logic             stable;
  logic             stable_d;
  logic [CNT_W-1:0] cnt;

  // Synchronize, accept a new level only after it held DEBOUNCE_CYCLES cycles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync     <= '0;
      stable   <= 1'b0;
      stable_d <= 1'b0;
      cnt      <= '0;
    end else begin
      sync     <= {sync[0], button};
      stable_d <= stable;
      if (sync[1] != stable) begin
        if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          stable <= sync[1];
          cnt    <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

  assign rise = stable & ~stable_d;
endmodule

// File: rtl/led_share_arbiter.sv
// Round-robin sharing of the single board status LED between N_REQ requesters.
// Each grant owns the LED for one slot, then the LED is dark for a gap.
// Optional manual advance by push-button: define LED_ARB_BUTTON_EN.
module led_share_arbiter
  import led_arb_pkg::*;
#(
  parameter int unsigned N_REQ           = 4,
  parameter int unsigned SLOT_CYCLES     = 50_000_000,
  parameter int unsigned GAP_CYCLES      = 1_000_000,
  parameter int unsigned SLOW_BIT        = 24,
  parameter int unsigned FAST_BIT        = 22,
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 button,
  led_share_arbiter_if.slave   bus
);
  localparam int unsigned PTR_W  = $clog2(N_REQ);
  localparam int unsigned SLOT_W = $clog2(SLOT_CYCLES);
  localparam int unsigned GAP_W  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  logic [1:0] rst_pipe;
  logic       rst_int;

  state_e              state, state_n;
  logic [N_REQ-1:0]    grant, grant_n;
  logic [PTR_W-1:0]    last_ptr, last_n;
  logic [SLOT_W-1:0]   slot_cnt, slot_n;
  logic [SLOW_BIT:0]   phase_cnt, phase_n;
  logic [GAP_W-1:0]    gap_cnt, gap_n;
  logic                led_q, led_n;
  logic                done_q, done_n;
  logic                owner_req;
  pat_e                owner_pat;
  logic                slot_end;
  logic                btn_rise;
  int unsigned         pick;

`ifdef LED_ARB_BUTTON_EN
  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_button_debounce (
    .clk    (clk),
    .rst    (rst_int),
    .button (button),
    .rise   (btn_rise)
  );
`else
  localparam int unsigned unused_debounce = DEBOUNCE_CYCLES;
  logic unused_button;
  assign unused_button = button;
  assign btn_rise      = 1'b0;
`endif

  // Reset asserts asynchronously, releases two clock edges later
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rst_pipe <= '1;
    else     rst_pipe <= {rst_pipe[0], 1'b0};
  end
  assign rst_int = rst_pipe[1];

  // last_ptr is the current owner while in GRANT
  assign owner_req = bus.req[last_ptr];
  assign owner_pat = pat_e'(bus.pattern[{last_ptr, 1'b0} +: 2]);
  assign slot_end  = (slot_cnt == SLOT_W'(SLOT_CYCLES - 1)) || !owner_req || btn_rise;
  assign pick      = rr_next(8'(bus.req), 32'(last_ptr), N_REQ);

  // State, counters and registered outputs
  always_ff @(posedge clk or posedge rst_int) begin
    if (rst_int) begin
      state     <= ST_IDLE;
      grant     <= '0;
      last_ptr  <= PTR_W'(N_REQ - 1);
      slot_cnt  <= '0;
      phase_cnt <= '0;
      gap_cnt   <= '0;
      led_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state     <= state_n;
      grant     <= grant_n;
      last_ptr  <= last_n;
      slot_cnt  <= slot_n;
      phase_cnt <= phase_n;
      gap_cnt   <= gap_n;
      led_q     <= led_n;
      done_q    <= done_n;
    end
  end

  // Next-state, arbitration and LED pattern mux
  always_comb begin
    state_n = state;
    grant_n = grant;
    last_n  = last_ptr;
    slot_n  = slot_cnt;
    phase_n = phase_cnt;
    gap_n   = gap_cnt;
    led_n   = 1'b0;
    done_n  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (|bus.req) begin
          last_n          = PTR_W'(pick);
          grant_n         = '0;
          grant_n[last_n] = 1'b1;
          slot_n          = '0;
          phase_n         = '0;
          state_n         = ST_GRANT;
        end
      end
      ST_GRANT: begin
        slot_n  = slot_cnt + 1'b1;
        phase_n = phase_cnt + 1'b1;
        case (owner_pat)
          PAT_OFF:  led_n = 1'b0;
          PAT_ON:   led_n = 1'b1;
          PAT_SLOW: led_n = phase_cnt[SLOW_BIT];
          PAT_FAST: led_n = phase_cnt[FAST_BIT];
          default:  led_n = 1'b0;
        endcase
        // Timeout, release and button share one exit, so one pulse at most
        if (slot_end) begin
          done_n  = 1'b1;
          grant_n = '0;
          led_n   = 1'b0;
          gap_n   = '0;
          state_n = ST_GAP;
        end
      end
      ST_GAP: begin
        grant_n = '0;
        gap_n   = gap_cnt + 1'b1;
        if (gap_cnt == GAP_W'(GAP_CYCLES - 1)) state_n = ST_IDLE;
      end
      default: begin
        grant_n = '0;
        state_n = ST_IDLE;
      end
    endcase
  end

  assign bus.led         = led_q;
  assign bus.grant       = grant;
  assign bus.grant_valid = |grant;
  assign bus.slot_done   = done_q;

endmodule

// File: tb/tb_led_share_arbiter.sv
// Directed bench for led_share_arbiter with a slot/gap timeline model.
module tb_led_share_arbiter;
  localparam int N    = 4;
  localparam int SLOT = 16;
  localparam int GAP  = 4;
  localparam int FB   = 1;
  localparam int SB   = 3;
  localparam int DEB  = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic button = 1'b0;

  always #5 clk = ~clk;

  led_share_arbiter_if #(.N_REQ(N)) bus ();

  led_share_arbiter #(
    .N_REQ(N), .SLOT_CYCLES(SLOT), .GAP_CYCLES(GAP),
    .SLOW_BIT(SB), .FAST_BIT(FB), .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clk(clk), .rst(rst), .button(button), .bus(bus)
  );

  int checks = 0;
  int errors = 0;
  bit model_on = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- timeline model ----------------
  // A slot starts on the edge a grant is decided and lasts SLOT edges unless
  // the owner drops its request; the next decision is GAP+1 edges after it ends.
  int       m_cyc   = 0;
  int       m_owner = -1;
  int       m_last  = N - 1;
  int       m_start = 0;
  int       m_ready = 0;
  int       m_hold  = 2;
  logic [3:0] e_grant = '0;
  logic       e_led   = 1'b0;
  logic       e_done  = 1'b0;

  function automatic logic pat_led(input logic [1:0] p, input int ph);
    case (p)
      2'b00:   return 1'b0;
      2'b01:   return 1'b1;
      2'b10:   return 1'((ph >> SB) & 1);
      default: return 1'((ph >> FB) & 1);
    endcase
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_owner = -1; m_last = N - 1; m_ready = 0; m_hold = 2;
      e_grant = '0; e_led = 1'b0; e_done = 1'b0;
    end else if (m_hold > 0) begin
      m_hold--;
    end else begin
      int age;
      logic [3:0] r;
      m_cyc++;
      r = bus.req;
      e_done = 1'b0;
      e_led  = 1'b0;
      if (m_owner >= 0) begin
        age = m_cyc - m_start;
        if (age == SLOT || !r[m_owner]) begin
          e_done  = 1'b1;
          e_grant = '0;
          m_owner = -1;
          m_ready = m_cyc + GAP + 1;
        end else begin
          e_led = pat_led(bus.pattern[2*m_owner +: 2], age - 1);
        end
      end else if (m_cyc >= m_ready && r != 0) begin
        for (int k = 1; k <= N; k++) begin
          int i;
          i = (m_last + k) % N;
          if (m_owner < 0 && r[i]) m_owner = i;
        end
        m_last  = m_owner;
        m_start = m_cyc;
        e_grant = 4'(1 << m_owner);
      end
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (model_on && !rst) begin
      check("led",         int'(bus.led),         int'(e_led));
      check("grant",       int'(bus.grant),       int'(e_grant));
      check("grant_valid", int'(bus.grant_valid), int'(|e_grant));
      check("slot_done",   int'(bus.slot_done),   int'(e_done));
    end
  end

  // ---------------- helpers ----------------
  task automatic wait_grant(output logic [3:0] g, output int zeros, output int gap_leds);
    zeros = 0; gap_leds = 0;
    while (!bus.grant_valid && zeros < 200) begin
      gap_leds += int'(bus.led);
      zeros++;
      @(negedge clk);
    end
    if (!bus.grant_valid) check("grant_timeout", 0, 1);
    g = bus.grant;
  endtask

  task automatic measure_slot(output int len, output int ons, output logic [15:0] bits);
    len = 0; ons = 0; bits = '0;
    while (bus.grant_valid && len < 100) begin
      if (len < 16) bits[len] = bus.led;
      ons += int'(bus.led);
      len++;
      @(negedge clk);
    end
    if (len >= 100) check("slot_timeout", 0, 1);
  endtask

  // ---------------- stimulus ----------------
  logic [3:0]  rr_exp [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [1:0]  pat_codes [3] = '{2'b11, 2'b10, 2'b00};
  logic [15:0] pat_bits  [3] = '{16'h9998, 16'hFE00, 16'h0000};

  initial begin
    logic [3:0]  g;
    logic [15:0] bits;
    int z, gl, len, ons, dn;

    bus.req = '0;
    bus.pattern = 8'b01010101;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    model_on = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_grant", int'(bus.grant), 0);
    check("reset_led",   int'(bus.led), 0);

    // Round-robin over four requesters
    bus.req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      wait_grant(g, z, gl);
      check("rr_grant", int'(g), int'(rr_exp[i]));
      if (i > 0) check("rr_gap_plus_idle", z, GAP + 1);
      measure_slot(len, ons, bits);
      check("rr_len", len, SLOT);
      check("rr_led_on", ons, SLOT - 1);
    end

    // Pattern codes on a single requester
    bus.req = 4'b0001;
    for (int i = 0; i < 3; i++) begin
      bus.pattern = {6'b010101, pat_codes[i]};
      wait_grant(g, z, gl);
      check("pat_grant", int'(g), 1);
      measure_slot(len, ons, bits);
      check("pat_bits", int'(bits), int'(pat_pits(i)));
    end

    // Early release of req[2] at slot cycle 5
    bus.pattern = 8'b01010101;
    bus.req = 4'b0101;
    wait_grant(g, z, gl);
    check("early_grant", int'(g), 4'b0100);
    repeat (5) @(negedge clk);
    bus.req = 4'b0001;
    @(negedge clk);
    check("early_done",  int'(bus.slot_done), 1);
    check("early_grant0", int'(bus.grant), 0);
    wait_grant(g, z, gl);
    check("early_gap", z, GAP + 1);
    check("early_next", int'(g), 4'b0001);
    measure_slot(len, ons, bits);

    // Single requester re-granted; last slot sees timeout and drop together
    bus.req = 4'b1000;
    wait_grant(g, z, gl);
    check("single_grant", int'(g), 4'b1000);
    for (int j = 0; j < 3; j++) begin
      if (j < 2) begin
        measure_slot(len, ons, bits);
        check("single_len", len, SLOT);
        wait_grant(g, z, gl);
        check("single_regrant", int'(g), 4'b1000);
        check("single_gap", z, GAP + 1);
        check("single_gap_led", gl, 0);
      end else begin
        repeat (15) @(negedge clk);
        bus.req = '0;
        dn = 0;
        for (int c = 0; c < 10; c++) begin
          @(negedge clk);
          dn += int'(bus.slot_done);
        end
        check("coincident_done_count", dn, 1);
      end
    end

    // Asynchronous reset in the middle of a slot
    bus.req = 4'b0100;
    wait_grant(g, z, gl);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_led",   int'(bus.led), 0);
    check("rst_grant", int'(bus.grant), 0);
    check("rst_valid", int'(bus.grant_valid), 0);
    check("rst_done",  int'(bus.slot_done), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Button during a slot
    bus.req = 4'b0010;
    wait_grant(g, z, gl);
    check("btn_grant", int'(g), 4'b0010);
`ifdef LED_ARB_BUTTON_EN
    model_on = 1'b0;
`endif
    begin
      bit ended;
      len = 0; dn = 0; ended = 1'b0;
      for (int n = 0; n < 40; n++) begin
        if (bus.grant_valid && !ended) len++;
        if (!bus.grant_valid) ended = 1'b1;
        if (!(ended && bus.grant_valid)) dn += int'(bus.slot_done);
        if (ended && bus.grant_valid) break;
        button = (n == 2) || (n >= 4 && n <= 8);
        @(negedge clk);
      end
      button = 1'b0;
    end
    check("btn_done_count", dn, 1);
`ifdef LED_ARB_BUTTON_EN
    check("btn_early", int'(len < SLOT), 1);
`else
    check("btn_full_len", len, SLOT);
`endif
    bus.req = '0;
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  function automatic logic [15:0] pat_pits(input int i);
    return pat_bits[i];
  endfunction

endmodule
